// File: rtl/nabp_image_stream_sink.sv
// nabp_image_stream_sink
//   Receiving end of the image-RAM write stream produced by the NABP image
//   addresser. Accepted beats go into a small FIFO, and the head of the FIFO
//   is committed to the internal image RAM once per cycle. The source is
//   throttled through a registered ir_enable. A pulse reports when a frame
//   has been fully committed. A host read port gives access to the image
//   whenever no frame is being received.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   reset_n    : asynchronous reset, active-high (despite the name)
//   ir_kick    : beat valid strobe from the addresser
//   ir_addr    : beat write address
//   ir_val     : beat write data
//   ir_done    : end-of-frame pulse
//   ir_enable  : registered "sink can accept a beat this cycle"
//   frame_done : one-cycle pulse, frame fully committed to RAM
//   err_drop   : sticky, a beat was dropped; cleared when the next frame starts
//   beat_count : beats committed in the current/last frame (saturating)
//   rd_en      : host read request
//   rd_addr    : host read address
//   rd_data    : host read data, one cycle after rd_en
//   rd_valid   : rd_data valid strobe
module nabp_image_stream_sink #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ir_kick,
  input  logic [ADDR_WIDTH-1:0] ir_addr,
  input  logic [DATA_WIDTH-1:0] ir_val,
  input  logic                  ir_done,
  output logic                  ir_enable,
  output logic                  frame_done,
  output logic                  err_drop,
  output logic [ADDR_WIDTH:0]   beat_count,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] SKID_LIMIT = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [ADDR_WIDTH:0] BEAT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_val  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;

  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

  logic accept_state;
  logic push;
  logic pop;
  logic drop;
  logic frame_start;
  logic host_ok;

  // A beat is only taken when the registered enable was high in an accepting
  // state. The extra full check only guards against a misbehaving source.
  // Any other kick is a drop. A frame starts on the first kick or done seen
  // in IDLE, even one that is dropped.
  always_comb begin
    accept_state = (state == IDLE) || (state == RECV);
    push         = ir_kick && ir_enable && accept_state && (count != FULL_COUNT);
    pop          = (count != '0);
    drop         = ir_kick && !push;
    frame_start  = (state == IDLE) && (ir_kick || ir_done);
    host_ok      = (state == IDLE) || (state == DONE);
    count_next   = count + CNT_W'(push) - CNT_W'(pop);
  end

  // State register
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic. DRAIN waits until the FIFO is empty. The pop that
  // empties it writes the RAM on the same edge, so no write is outstanding
  // once the count reads zero.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ir_done)      state_next = DRAIN;
        else if (ir_kick) state_next = RECV;
      end
      RECV:  if (ir_done) state_next = DRAIN;
      DRAIN: if (count == '0) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    frame_done = (state == DONE);
  end

  // The enable is looked ahead one cycle. The limit leaves one free slot for
  // the beat the source may still present while it reacts to a deassert.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) ir_enable <= 1'b0;
    else         ir_enable <= ((state_next == IDLE) || (state_next == RECV)) &&
                              (count_next <= SKID_LIMIT);
  end

  // FIFO pointers and occupancy. Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // FIFO payload storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ir_addr;
      fifo_val[wr_ptr]  <= ir_val;
    end
  end

  // Image RAM commit. The RAM has no reset. After a reset the count is zero,
  // so anything still queued is never written.
  always_ff @(posedge clk) begin
    if (pop) ram[fifo_addr[rd_ptr]] <= fifo_val[rd_ptr];
  end

  // Frame status. err_drop is reloaded at frame start rather than simply
  // cleared. A frame opened by a dropped kick therefore still reports the drop.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      err_drop   <= 1'b0;
      beat_count <= '0;
    end else begin
      if (frame_start) err_drop <= drop;
      else if (drop)   err_drop <= 1'b1;

      if (frame_start)                        beat_count <= '0;
      else if (pop && (beat_count != BEAT_MAX)) beat_count <= beat_count + 1'b1;
    end
  end

  // Host read port, only served outside reception. A commit on the same edge
  // is not visible, so the old word is returned.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en && host_ok;
      if (rd_en && host_ok) rd_data <= ram[rd_addr];
    end
  end

endmodule

// File: tb/tb_nabp_image_stream_sink.sv
// tb_nabp_image_stream_sink
//   Directed self-checking bench for nabp_image_stream_sink. Each scenario
//   task drives its own stimulus and compares the outputs against values
//   worked out by hand. The outputs are sampled 1 time unit after the rising edge.
module tb_nabp_image_stream_sink;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ir_kick;
  logic [5:0]  ir_addr;
  logic [15:0] ir_val;
  logic        ir_done;
  logic        ir_enable;
  logic        frame_done;
  logic        err_drop;
  logic [6:0]  beat_count;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;

  int checks = 0;
  int errors = 0;

  nabp_image_stream_sink #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ir_kick(ir_kick), .ir_addr(ir_addr), .ir_val(ir_val), .ir_done(ir_done),
    .ir_enable(ir_enable), .frame_done(frame_done), .err_drop(err_drop),
    .beat_count(beat_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns with frame_done visible. If the pulse never arrives, the timeout is counted as a failure.
  task automatic wait_frame_done(input string tag);
    int n = 0;
    while (!frame_done && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (!frame_done) begin
      errors++;
      $display("[TB] FAIL %s frame_done timeout: got 0 required 1 within 40 cycles", tag);
    end
  endtask

  task automatic do_read(input logic [5:0] a, output logic [15:0] d, output logic v);
    rd_en = 1'b1;
    rd_addr = a;
    step();
    d = rd_data;
    v = rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    ir_kick = 1'b0; ir_addr = '0; ir_val = '0; ir_done = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    step(); step();
    checks++; if (ir_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset ir_enable: got %b required 0", ir_enable); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset frame_done: got %b required 0", frame_done); end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("[TB] FAIL reset err_drop: got %b required 0", err_drop); end
    checks++; if (beat_count !== 7'd0) begin errors++; $display("[TB] FAIL reset beat_count: got %0d required 0", beat_count); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin errors++; $display("[TB] FAIL reset rd: got %b/%h required 0/0000", rd_valid, rd_data); end
    reset_n = 1'b0;
    step();
    checks++; if (ir_enable !== 1'b1) begin errors++; $display("[TB] FAIL reset release ir_enable: got %b required 1", ir_enable); end
  endtask

  task automatic test_single_frame();
    logic [15:0] d;
    logic v;
    logic [5:0]  addrs [3] = '{6'd0, 6'd1, 6'd63};
    logic [15:0] vals  [3] = '{16'h0011, 16'h0022, 16'hBEEF};
    for (int i = 0; i < 3; i++) begin
      ir_kick = 1'b1; ir_addr = addrs[i]; ir_val = vals[i];
      step();
    end
    ir_kick = 1'b0; ir_done = 1'b1;
    step();
    ir_done = 1'b0;
    wait_frame_done("single");
    checks++; if (beat_count !== 7'd3) begin errors++; $display("[TB] FAIL single beat_count: got %0d required 3", beat_count); end
    do_read(6'd63, d, v);
    checks++; if (v !== 1'b1 || d !== 16'hBEEF) begin errors++; $display("[TB] FAIL single read63: got %b/%h required 1/beef", v, d); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL single frame_done width: got %b required 0", frame_done); end
    do_read(6'd1, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0022) begin errors++; $display("[TB] FAIL single read1: got %b/%h required 1/0022", v, d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic v;
    for (int i = 0; i < 64; i++) begin
      int g = 0;
      while (!ir_enable && g < 20) begin
        ir_kick = 1'b0;
        step();
        g++;
      end
      ir_kick = 1'b1; ir_addr = 6'(i); ir_val = 16'(i * 3);
      step();
    end
    ir_kick = 1'b0; ir_done = 1'b1;
    step();
    ir_done = 1'b0;
    wait_frame_done("burst");
    checks++; if (beat_count !== 7'd64) begin errors++; $display("[TB] FAIL burst beat_count: got %0d required 64", beat_count); end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("[TB] FAIL burst err_drop: got %b required 0", err_drop); end
    step();
    for (int i = 0; i < 64; i++) begin
      do_read(6'(i), d, v);
      checks++;
      if (v !== 1'b1 || d !== 16'(i * 3)) begin
        errors++;
        $display("[TB] FAIL burst readback addr %0d: got %b/%h required 1/%h", i, v, d, 16'(i * 3));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] d;
    logic v;
    for (int i = 0; i < 3; i++) begin
      ir_kick = 1'b1; ir_addr = 6'(20 + i); ir_val = 16'(16'hA0 + i);
      step();
    end
    ir_kick = 1'b0;
    reset_n = 1'b1;
    #1;
    checks++; if (ir_enable !== 1'b0) begin errors++; $display("[TB] FAIL midreset ir_enable: got %b required 0", ir_enable); end
    checks++; if (beat_count !== 7'd0) begin errors++; $display("[TB] FAIL midreset beat_count: got %0d required 0", beat_count); end
    step(); step();
    reset_n = 1'b0;
    step();
    checks++; if (ir_enable !== 1'b1) begin errors++; $display("[TB] FAIL midreset release ir_enable: got %b required 1", ir_enable); end
    do_read(6'd22, d, v);
    checks++; if (d !== 16'd66) begin errors++; $display("[TB] FAIL midreset queued beat written: got %h required 0042", d); end
    do_read(6'd21, d, v);
    checks++; if (d !== 16'h00A1) begin errors++; $display("[TB] FAIL midreset committed beat: got %h required 00a1", d); end
  endtask

  task automatic test_drop();
    logic [15:0] d;
    logic v;
    reset_n = 1'b1;
    step();
    reset_n = 1'b0;
    ir_kick = 1'b1; ir_addr = 6'd10; ir_val = 16'hDEAD;
    step();
    checks++; if (err_drop !== 1'b1) begin errors++; $display("[TB] FAIL drop disabled kick err_drop: got %b required 1", err_drop); end
    ir_addr = 6'd11; ir_val = 16'h0077;
    step();
    ir_kick = 1'b0; ir_done = 1'b1;
    step();
    ir_done = 1'b0;
    ir_kick = 1'b1; ir_addr = 6'd12; ir_val = 16'h0BAD;
    step();
    ir_kick = 1'b0;
    wait_frame_done("drop");
    checks++; if (beat_count !== 7'd1) begin errors++; $display("[TB] FAIL drop beat_count: got %0d required 1", beat_count); end
    step();
    checks++; if (err_drop !== 1'b1) begin errors++; $display("[TB] FAIL drop sticky: got %b required 1", err_drop); end
    do_read(6'd10, d, v);
    checks++; if (d !== 16'd30) begin errors++; $display("[TB] FAIL drop addr10: got %h required 001e", d); end
    do_read(6'd12, d, v);
    checks++; if (d !== 16'd36) begin errors++; $display("[TB] FAIL drop addr12: got %h required 0024", d); end
    do_read(6'd11, d, v);
    checks++; if (d !== 16'h0077) begin errors++; $display("[TB] FAIL drop addr11: got %h required 0077", d); end
  endtask

  task automatic test_boundaries();
    logic [15:0] d;
    logic v;
    ir_kick = 1'b1; ir_addr = 6'd5; ir_val = 16'h0001;
    step();
    checks++; if (err_drop !== 1'b0) begin errors++; $display("[TB] FAIL bound err_drop clear: got %b required 0", err_drop); end
    ir_val = 16'h0002; ir_done = 1'b1;
    step();
    ir_kick = 1'b0; ir_done = 1'b0;
    wait_frame_done("kickdone");
    checks++; if (beat_count !== 7'd2) begin errors++; $display("[TB] FAIL bound kick+done beat_count: got %0d required 2", beat_count); end
    step();
    do_read(6'd5, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0002) begin errors++; $display("[TB] FAIL bound dup addr5: got %b/%h required 1/0002", v, d); end
    ir_done = 1'b1;
    step();
    ir_done = 1'b0;
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL bound empty early: got %b required 0", frame_done); end
    step();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL bound empty frame_done: got %b required 1", frame_done); end
    checks++; if (beat_count !== 7'd0) begin errors++; $display("[TB] FAIL bound empty beat_count: got %0d required 0", beat_count); end
    step();
  endtask

  task automatic test_host_read();
    logic [15:0] d;
    logic v;
    ir_kick = 1'b1; ir_addr = 6'd40; ir_val = 16'h4040;
    step();
    ir_kick = 1'b0;
    do_read(6'd63, d, v);
    checks++; if (v !== 1'b0) begin errors++; $display("[TB] FAIL host read in RECV rd_valid: got %b required 0", v); end
    ir_done = 1'b1;
    step();
    ir_done = 1'b0;
    wait_frame_done("hostread");
    do_read(6'd40, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h4040) begin errors++; $display("[TB] FAIL host read in DONE: got %b/%h required 1/4040", v, d); end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL host rd_valid drop: got %b required 0", rd_valid); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_drop();
    test_boundaries();
    test_host_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
